// File: rtl/display_board_ram_if.sv
// Command/read bundle between the game logic (master) and the 8x8 two-colour board RAM (slave).
interface display_board_ram_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_pos;
  logic [1:0] cmd_data;
  logic       done;
  logic [6:0] count;
  logic [5:0] rd_addr;
  logic [1:0] rd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_pos, cmd_data, rd_addr,
    input  cmd_ready, done, count, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_pos, cmd_data, rd_addr,
    output cmd_ready, done, count, rd_data
  );
endinterface

// File: rtl/display_board_ram.sv
// 8x8 x 2-bit LED board image: WRITE/FILL/ROW/COUNT command port plus a combinational read port.
// Define DISPLAY_BOARD_RAM_COUNT_EN to build COUNT; otherwise op 2'b11 is a one-cycle NOP.
module display_board_ram (
  input  logic               clk,
  input  logic               rst,
  display_board_ram_if.slave bus
);
  typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_FILL = 2'b01, OP_ROW = 2'b10, OP_COUNT = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t     state;
  op_t        op_q;
  op_t        cmd_op;
  logic [1:0] data_q;
  logic [5:0] addr_q;
  logic [5:0] last_q;
  logic       done_q;
  logic       accept;
  logic       sweep_end;

  logic [1:0] mem [64];
  logic       we;
  logic [5:0] waddr;
  logic [1:0] wdata;

  assign cmd_op        = op_t'(bus.cmd_op);
  assign accept        = bus.cmd_valid && (state == IDLE);
  assign sweep_end     = (addr_q == last_q);
  assign bus.cmd_ready = (state == IDLE);
  assign bus.done      = done_q;
  assign bus.rd_data   = mem[bus.rd_addr];

  // A single write port: direct WRITE on the accept edge, or one cell per FILL/ROW sweep edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    we    = 1'b0;
    waddr = addr_q;
    wdata = data_q;
    if (accept && cmd_op == OP_WRITE) begin
      we    = 1'b1;
      waddr = bus.cmd_pos;
      wdata = bus.cmd_data;
    end else if (state == SWEEP && op_q != OP_COUNT) begin
      we = 1'b1;
    end
  end

  // NOTE: the board is 64 flops, not a RAM macro, so it is legal and required to clear it on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 2'b00;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_WRITE;
      data_q <= 2'b00;
      addr_q <= 6'd0;
      last_q <= 6'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= cmd_op;
            data_q <= bus.cmd_data;
            case (cmd_op)
              OP_FILL: begin
                addr_q <= 6'd0;
                last_q <= 6'd63;
                state  <= SWEEP;
              end
              OP_ROW: begin
                addr_q <= {bus.cmd_pos[5:3], 3'b000};
                last_q <= {bus.cmd_pos[5:3], 3'b111};
                state  <= SWEEP;
              end
`ifdef DISPLAY_BOARD_RAM_COUNT_EN
              OP_COUNT: begin
                addr_q <= 6'd0;
                last_q <= 6'd63;
                state  <= SWEEP;
              end
`endif
              default: begin
                state  <= DONE;
                done_q <= 1'b1;
              end
            endcase
          end
        end
        SWEEP: begin
          if (sweep_end) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            addr_q <= addr_q + 6'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPLAY_BOARD_RAM_COUNT_EN
  logic [6:0] acc_q;
  logic [6:0] count_q;
  logic [6:0] acc_next;

  // 7-bit accumulator holds the full 0..64 range, so a board of all matches reads 64.
  assign acc_next  = acc_q + {6'd0, (mem[addr_q] == data_q)};
  assign bus.count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= 7'd0;
      count_q <= 7'd0;
    end else if (accept && cmd_op == OP_COUNT) begin
      acc_q <= 7'd0;
    end else if (state == SWEEP && op_q == OP_COUNT) begin
      acc_q <= acc_next;
      if (sweep_end) count_q <= acc_next;
    end
  end
`else
  assign bus.count = 7'd0;
`endif

endmodule

// File: tb/tb_display_board_ram.sv
// Scoreboard bench for display_board_ram: stimulus queues expected done cycle/count, a monitor checks.
module tb_display_board_ram;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  display_board_ram_if bus ();

  display_board_ram dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         due;
    logic [6:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] exp_mem [64];
  logic [6:0] exp_count;
`ifdef DISPLAY_BOARD_RAM_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always begin
    @(negedge clk);
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        fail_now($sformatf("unexpected done at cycle %0d", cyc));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, " done cycle"}, cyc, e.due);
        check({e.name, " count"}, bus.count, e.cnt);
      end
    end
  end

  // Issue one command; lat = cycles from accept edge to the edge where done is first seen high.
  task automatic send(input logic [1:0] op, input logic [5:0] pos, input logic [1:0] data,
                      input int lat, input logic [6:0] cnt, input string name,
                      input bit expect_done, output int acc_cyc);
    int n = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (bus.cmd_ready !== 1'b1) fail_now({name, " ready timeout"});
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_pos   = pos;
    bus.cmd_data  = data;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (expect_done) sb.push_back('{name, cyc + lat - 1, cnt});
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'bxx;
    bus.cmd_pos   = 6'hxx;
    bus.cmd_data  = 2'bxx;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb.size() != 0 || bus.cmd_ready !== 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      fail_now({name, " done timeout"});
      sb.delete();
    end
  endtask

  task automatic check_board(input string name);
    for (int a = 0; a < 64; a++) begin
      bus.rd_addr = 6'(a);
      #1;
      check($sformatf("%s cell %0d", name, a), bus.rd_data, exp_mem[a]);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #3;
    rst = 1'b0;
    for (int a = 0; a < 64; a++) exp_mem[a] = 2'b00;
    exp_count = 7'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    int a1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_pos   = 6'd0;
    bus.cmd_data  = 2'b00;
    bus.rd_addr   = 6'd0;
    for (int a = 0; a < 64; a++) exp_mem[a] = 2'b00;
    exp_count = 7'd0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset cmd_ready", bus.cmd_ready, 1);
    check("reset count", bus.count, 0);
    check("reset done", bus.done, 0);
    check_board("reset");

    // Single WRITE: one-cycle latency, ready low exactly one cycle
    send(2'b00, 6'o35, 2'b10, 1, exp_count, "write o35", 1'b1, a0);
    exp_mem[29] = 2'b10;
    check("write ready low after accept", bus.cmd_ready, 0);
    @(posedge clk);
    #1;
    check("write ready back high", bus.cmd_ready, 1);
    wait_idle("write o35");
    check_board("after write");

    // FILL 01 while watching cell 63 flip on the 64th sweep edge
    bus.rd_addr = 6'd63;
    send(2'b01, 6'd0, 2'b01, 65, exp_count, "fill 01", 1'b1, a0);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (cyc == a0 + 63) check("fill cell63 before last edge", bus.rd_data, 2'b00);
      if (cyc == a0 + 64) check("fill cell63 at last edge", bus.rd_data, 2'b01);
    end
    for (int a = 0; a < 64; a++) exp_mem[a] = 2'b01;
    wait_idle("fill 01");
    check_board("after fill");

    // ROW 2 = 10
    send(2'b10, {3'd2, 3'd5}, 2'b10, 9, exp_count, "row 2", 1'b1, a0);
    for (int a = 16; a < 24; a++) exp_mem[a] = 2'b10;
    wait_idle("row 2");
    check_board("after row");

    // Five WRITEs on a cleared board, then COUNT 10 and COUNT 00
    pulse_reset();
    #1;
    check("count cleared by reset", bus.count, 0);
    send(2'b00, 6'd0,  2'b10, 1, exp_count, "w0",  1'b1, a0);
    send(2'b00, 6'd9,  2'b10, 1, exp_count, "w9",  1'b1, a1);
    check("back-to-back write spacing", a1 - a0, 2);
    send(2'b00, 6'd27, 2'b10, 1, exp_count, "w27", 1'b1, a0);
    send(2'b00, 6'd45, 2'b10, 1, exp_count, "w45", 1'b1, a0);
    send(2'b00, 6'd63, 2'b10, 1, exp_count, "w63", 1'b1, a0);
    exp_mem[0] = 2'b10; exp_mem[9] = 2'b10; exp_mem[27] = 2'b10;
    exp_mem[45] = 2'b10; exp_mem[63] = 2'b10;
    if (COUNT_EN) begin
      send(2'b11, 6'd0, 2'b10, 65, 7'd5, "count 10", 1'b1, a0);
      exp_count = 7'd5;
      send(2'b11, 6'd0, 2'b00, 65, 7'd59, "count 00", 1'b1, a0);
      exp_count = 7'd59;
    end else begin
      send(2'b11, 6'd0, 2'b10, 1, 7'd0, "nop 10", 1'b1, a0);
      send(2'b11, 6'd17, 2'b00, 1, 7'd0, "nop 00", 1'b1, a0);
    end
    wait_idle("count");
    check("count holds", bus.count, exp_count);
    check_board("after count");

    // cmd_valid held through a FILL with a WRITE waiting behind it
    send(2'b01, 6'd0, 2'b11, 65, exp_count, "fill 11", 1'b1, a0);
    sb.push_back('{"held write", a0 + 66, exp_count});
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_pos   = 6'd7;
    bus.cmd_data  = 2'b01;
    begin
      int n = 0;
      @(negedge clk);
      while (bus.cmd_ready !== 1'b1 && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) fail_now("held write ready timeout");
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    for (int a = 0; a < 64; a++) exp_mem[a] = 2'b11;
    exp_mem[7] = 2'b01;
    wait_idle("held write");
    check_board("after held write");

    // Reset in the middle of a FILL sweep: no done, board and count cleared
    send(2'b01, 6'd0, 2'b10, 65, exp_count, "aborted fill", 1'b0, a0);
    while (cyc < a0 + 20) @(negedge clk);
    rst = 1'b1;
    #3;
    rst = 1'b0;
    for (int a = 0; a < 64; a++) exp_mem[a] = 2'b00;
    exp_count = 7'd0;
    #1;
    check("abort cmd_ready", bus.cmd_ready, 1);
    check("abort count", bus.count, 0);
    check("abort done", bus.done, 0);
    check_board("after abort");
    repeat (80) @(negedge clk);
    check_board("after abort settle");

    wait_idle("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/display_board_ram.md
# display_board_ram

- Holds the 8×8 two-colour board image shown on the LED matrix: 64 cells × 2 bits, bit1 = red, bit0 = green.
- Write side: game logic issues commands on a valid/ready port: single-point write, full-board fill, row fill and occupancy count.
- Read side: combinational port addressed as {row[2:0], col[2:0]}, consumed by the LED scan logic.

## Interface
Parameters: none (geometry fixed at 8×8, 2 bits per cell).
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_op  in  2  00 WRITE, 01 FILL, 10 ROW, 11 COUNT
- cmd_pos  in  6  {row, col}; ROW uses cmd_pos[5:3] only; FILL/COUNT ignore it
- cmd_data  in  2  cell value to write, or value to match for COUNT; 2'b11 stored/matched as-is
- done  out  1  one-cycle pulse when a command completes
- count  out  7  result of last COUNT (0..64)
- rd_addr  in  6  read address {row, col}
- rd_data  out  2  mem[rd_addr], combinational

## Operation
- Storage: 64 × 2-bit registers, all cleared to 2'b00 by rst.
- Handshake: command accepted on a rising edge with cmd_valid && cmd_ready. cmd_op/pos/data are latched at acceptance and may change afterwards. cmd_valid while busy is ignored (not queued).
- FSM states: IDLE, SWEEP, DONE.
  - IDLE + accept WRITE: mem[cmd_pos] <= cmd_data on the accept edge -> DONE.
  - IDLE + accept FILL: sweep address <= 0, last <= 63 -> SWEEP.
  - IDLE + accept ROW: sweep address <= {row, 3'b000}, last <= {row, 3'b111} -> SWEEP.
  - IDLE + accept COUNT: sweep address <= 0, accumulator <= 0 -> SWEEP.
  - SWEEP, each edge:
    - FILL/ROW: mem[addr] <= latched data.
    - COUNT: accumulator += (mem[addr] == latched data).
    - addr == last -> DONE; otherwise addr += 1.
  - DONE: done = 1 for exactly one cycle; COUNT loads count from the final accumulator on the SWEEP→DONE edge. DONE -> IDLE unconditionally.
- count holds its value until the next COUNT completes. Other ops do not alter it.
- Accumulator is 7 bits, so 64 matches gives count = 7'd64 with no wrap. The sweep address is 6 bits and stops at last, so it never wraps.
- Read port is independent of the FSM: rd_data reflects mem contents after the most recent edge. A write to the address being read becomes visible the cycle after the write edge.
- rst asserted mid-sweep: immediate return to IDLE, memory cleared, done = 0, count = 0. The aborted command has no remaining effect.

## Timing
- Reset values: cmd_ready = 1, done = 0, count = 0, rd_data = 2'b00 for every address.
- cmd_ready is combinational from state (state == IDLE), with no dependence on cmd_valid.
- Latency, counted from the accept edge to the edge at which done is first high:
  - WRITE: 1 cycle.
  - FILL: 65 cycles.
  - ROW: 9 cycles.
  - COUNT: 65 cycles.
- cmd_ready returns high the cycle after done.
- Maximum throughput: one WRITE every 2 cycles.

## Configuration
- DISPLAY_BOARD_RAM_COUNT_EN defined: COUNT implemented as described.
- Not defined: op 11 is a NOP. It is accepted, goes directly to DONE (1-cycle latency, same as WRITE), and alters no memory. count is tied to 7'd0, and the accumulator and comparator are not built.

## Test plan
- Reset release -> cmd_ready = 1; rd_data = 00 for all 64 rd_addr values; count = 0.
- WRITE pos=6'o35 data=10 -> done 1 cycle after accept; rd_data at 6'o35 = 10, all other cells 00; cmd_ready low exactly one cycle.
- FILL data=01 with rd_addr=63 monitored, then ROW pos[5:3]=2 data=10:
  - FILL: rd_addr 63 changes to 01 on the 64th SWEEP edge; done 65 cycles after accept.
  - ROW: cells 16..23 = 10, all other cells stay 01; done 9 cycles after accept.
- Five WRITEs of 10 to distinct cells on a cleared board, then COUNT data=10 -> count = 5 at done. A following COUNT data=00 -> count = 59.
- cmd_valid held high throughout a FILL with a different op -> that op is not accepted until cmd_ready returns. rst pulsed at SWEEP cycle 20 of a FILL -> all cells 00, done never pulses, cmd_ready = 1 after reset release.
- Build without DISPLAY_BOARD_RAM_COUNT_EN, issue op 11 -> done 1 cycle after accept, count = 0, memory unchanged.
